dsp_post_adder_acc: RTL
=======================

Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP48A1 slice datapath.
- Sits directly downstream of the M (multiplier) pipe stage and consumes its 36-bit product.
- Selects X/Z operands by OPMODE and adds or subtracts them with a carry-in, which may be registered.
- Produces the 48-bit P result, the PCOUT cascade and carry-out, each with optional output registers.

Parameters:
PREG, 1, 1 = p output taken from P register; 0 = combinational post-adder result on p.
CARRYINREG, 1, 1 = carry-in passes through the CYI register; 0 = bypass.
CARRYOUTREG, 1, 1 = carryout taken from the CYO register; 0 = combinational.
CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" = opmode[5]; "CARRYIN" = carryin port; any other value = constant 0.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset for all registers in the block.
clkenp  in  1  enable for the P and CYO registers.
clkencyi  in  1  enable for the CYI register.
opmode  in  8  bits [1:0] select X, bits [3:2] select Z, bit [5] = carry value, bit [7] = subtract; bits 4 and 6 ignored.
m_in  in  36  product from the M pipe stage.
dab_in  in  48  concatenation {D[11:0], A[17:0], B[17:0]}.
c_in  in  48  C operand, already staged.
pcin  in  48  cascade input from the previous slice.
carryin  in  1  external carry-in.
p  out  48  result.
pcout  out  48  always equal to the P register, regardless of PREG.
carryout  out  1  carry/borrow out.
carryoutf  out  1  identical copy of carryout for fabric routing.

Behaviour:
- Reset:
  - rst high clears P, CYI and CYO registers immediately, independent of clk.
  - While rst is high: p=0 (when PREG=1), pcout=0, carryout=carryoutf=0 (when CARRYOUTREG=1).
  - Reset dominates enables and takes effect mid-accumulation; the next cycle after release starts from P=0.
- X mux (opmode[1:0]):
  - 0: 48'h0.
  - 1: m_in, zero-extended to 48 bits.
  - 2: P register.
  - 3: dab_in.
- Z mux (opmode[3:2]):
  - 0: 48'h0.
  - 1: pcin.
  - 2: P register.
  - 3: c_in.
- Feedback: P feedback always sources the internal P register. The P register updates on clkenp even when PREG=0, so accumulation works in both settings.
- Carry-in path:
  - cin_src is chosen per CARRYINSEL.
  - CARRYINREG=1: CYI loads cin_src on posedge clk when clkencyi=1, and cin = CYI.
  - CARRYINREG=0: cin = cin_src.
- Arithmetic, 49-bit unsigned, no saturation, wraps modulo 2^48:
  - opmode[7]=0: {co, r} = Z + X + cin.
  - opmode[7]=1: {co, r} = {0,Z} − {0,X} − cin; co = bit 48, where 1 = borrow.
- P register: on posedge clk with clkenp=1, P ← r and CYO ← co. With clkenp=0 both hold.
- Latency:
  - PREG=1: operands to p in 1 clock.
  - PREG=0: 0 clocks.
  - CARRYINREG adds 1 clock to the carry path only. Upstream aligns opmode[5]/carryin accordingly.
- Simultaneous events: X=P and Z=P in the same cycle gives 2·P + cin, which is legal.
- Unused opmode bits have no effect.

Optional Feature:
- Macro: DSP_POST_ACC_OVF_EN.
- Defined:
  - Adds input ovf_clr (1) and output ovf (1, sticky signed overflow).
  - On a clkenp cycle, ovf sets when the signed 48-bit result overflows:
    - add: X and Z have the same sign and r has the opposite sign;
    - subtract: Z and X have different signs and r's sign differs from Z.
  - ovf_clr=1 clears ovf synchronously; if overflow occurs in the same cycle, set wins.
  - rst clears ovf.
- Undefined: both ports are absent, no flag logic exists, and remaining behaviour is identical.

Test Plan:
- Reset check: assert rst mid-cycle with P=48'h123 → p, pcout, carryout are 0 asynchronously, before the next edge.
- Multiply-accumulate: PREG=1, opmode=8'h09 (X=M, Z=P), m_in=5 for 4 cycles with clkenp=1 → p=5, 10, 15, 20 on successive cycles; drop clkenp for 2 cycles → p holds 20.
- Subtract and borrow: opmode=8'h8D (sub, X=M, Z=C), c_in=3, m_in=5, CARRYINSEL="OPMODE5", cin=0 → p=48'hFFFF_FFFF_FFFE, carryout=1.
- Carry-in register latency: CARRYINSEL="CARRYIN", CARRYINREG=1, X=dab_in=48'hFFFF_FFFF_FFFF, Z=0, carryin pulsed for 1 cycle → p=0 and carryout=1 two edges after the pulse; PREG=0/CARRYINREG=0 gives the result in the same cycle.
- Cascade: Z=pcin=48'h8000_0000_0000, X=dab_in=48'h8000_0000_0000, add → p=0, carryout=1, pcout=0; with DSP_POST_ACC_OVF_EN, ovf=1 and holds until ovf_clr.

Source files
------------

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1-style post-adder/accumulator: X/Z operand muxes, add/subtract with carry-in,
// optional P/CYI/CYO registers. Define DSP_POST_ACC_OVF_EN for the sticky signed-overflow flag.
module dsp_post_adder_acc #(
  parameter int PREG        = 1,
  parameter int CARRYINREG  = 1,
  parameter int CARRYOUTREG = 1,
  parameter     CARRYINSEL  = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkenp,
  input  logic        clkencyi,
  input  logic [7:0]  opmode,
  input  logic [35:0] m_in,
  input  logic [47:0] dab_in,
  input  logic [47:0] c_in,
  input  logic [47:0] pcin,
  input  logic        carryin,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout,
  output logic        carryoutf
`ifdef DSP_POST_ACC_OVF_EN
  ,
  input  logic        ovf_clr,
  output logic        ovf
`endif
);

  logic [47:0] r_p;
  logic        r_cyo;
  logic        r_cyi;
  logic [47:0] w_x;
  logic [47:0] w_z;
  logic        w_cin_src;
  logic        w_cin;
  logic [48:0] w_sum;
  logic        w_unused;

  // X operand select
  always_comb begin
    w_x = 48'h0;
    case (opmode[1:0])
      2'd0:    w_x = 48'h0;
      2'd1:    w_x = {12'h0, m_in};
      2'd2:    w_x = r_p;
      2'd3:    w_x = dab_in;
      default: w_x = 48'h0;
    endcase
  end

  // Z operand select
  always_comb begin
    w_z = 48'h0;
    case (opmode[3:2])
      2'd0:    w_z = 48'h0;
      2'd1:    w_z = pcin;
      2'd2:    w_z = r_p;
      2'd3:    w_z = c_in;
      default: w_z = 48'h0;
    endcase
  end

  // Carry-in source; unrecognised selector values tie the carry to zero
  always_comb begin
    w_cin_src = 1'b0;
    if (CARRYINSEL == "OPMODE5") begin
      w_cin_src = opmode[5];
    end else if (CARRYINSEL == "CARRYIN") begin
      w_cin_src = carryin;
    end else begin
      w_cin_src = 1'b0;
    end
  end

  assign w_cin = (CARRYINREG != 0) ? r_cyi : w_cin_src;

  // 49-bit add/subtract; bit 48 is carry on add, borrow on subtract
  always_comb begin
    w_sum = 49'h0;
    if (opmode[7]) begin
      w_sum = {1'b0, w_z} - {1'b0, w_x} - {48'h0, w_cin};
    end else begin
      w_sum = {1'b0, w_z} + {1'b0, w_x} + {48'h0, w_cin};
    end
  end

  // Carry-in register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyi <= 1'b0;
    end else if (clkencyi) begin
      r_cyi <= w_cin_src;
    end
  end

  // P and carry-out registers; P always updates so feedback works with PREG=0 too
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p   <= 48'h0;
      r_cyo <= 1'b0;
    end else if (clkenp) begin
      r_p   <= w_sum[47:0];
      r_cyo <= w_sum[48];
    end
  end

  assign p         = (PREG != 0) ? r_p : w_sum[47:0];
  assign pcout     = r_p;
  assign carryout  = (CARRYOUTREG != 0) ? r_cyo : w_sum[48];
  assign carryoutf = carryout;
  assign w_unused  = ^{opmode[6], opmode[4]};

`ifdef DSP_POST_ACC_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Signed overflow of the 48-bit result, judged against operand signs
  always_comb begin
    w_ovf = 1'b0;
    if (opmode[7]) begin
      w_ovf = (w_z[47] != w_x[47]) && (w_sum[47] != w_z[47]);
    end else begin
      w_ovf = (w_z[47] == w_x[47]) && (w_sum[47] != w_x[47]);
    end
  end

  // Sticky flag: a new overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (clkenp && w_ovf) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
